// File: rtl/i2c_page_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_page_sequencer
//
// Drives an external I2C byte engine to perform one EEPROM page write:
// device-select byte (with START), memory address byte, then 1..16 data
// bytes taken from a 16x8 page buffer (STOP on the last one).
// A NACK in any of those phases triggers a stop-only transaction and ends
// the sequence with an error.
//
// Optional feature (macro PAGESEQ_ACKPOLL_EN): after the last data byte the
// sequencer ACK-polls the device (START + devsel-write + STOP) until it
// acknowledges, giving up after POLL_LIMIT NACKed attempts.
//
// Ports
//   clock, reset         system clock, synchronous active-high reset
//   start                one-cycle page-write request (ignored while busy)
//   chip_sel[2:0]        E2..E0 pins, placed in devsel bits 3..1
//   mem_addr[7:0]        start byte address, sampled on start
//   len[4:0]             byte count 1..16, sampled on start
//   buf_we/waddr/wdata   page buffer write port (ignored while busy)
//   eng_go               one-cycle launch of a byte-engine transaction
//   eng_start/byte_en/stop  phase selects of that transaction
//   eng_byte[7:0]        byte to transmit
//   eng_done, eng_ack    engine completion pulse and ACK flag (1 = ACK)
//   busy, done           sequence active / one-cycle completion pulse
//   err_code[1:0]        0 ok, 1 bad length, 2 NACK, 3 poll timeout
// ---------------------------------------------------------------------------
module i2c_page_sequencer #(
    parameter int POLL_LIMIT = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] chip_sel,
    input  logic [7:0] mem_addr,
    input  logic [4:0] len,
    input  logic       buf_we,
    input  logic [3:0] buf_waddr,
    input  logic [7:0] buf_wdata,
    output logic       eng_go,
    output logic       eng_start,
    output logic       eng_byte_en,
    output logic       eng_stop,
    output logic [7:0] eng_byte,
    input  logic       eng_done,
    input  logic       eng_ack,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEVSEL,
        ST_ADDR,
        ST_DATA,
        ST_ABORT,
`ifdef PAGESEQ_ACKPOLL_EN
        ST_POLL,
`endif
        ST_FINISH
    } state_t;

    state_t     state_reg;
    logic [7:0] addr_reg;
    logic [2:0] chip_reg;
    logic [3:0] idx_reg;      // next buffer index to send, wraps 15 -> 0
    logic [4:0] remain_reg;   // data bytes not yet acknowledged
    logic       wait_reg;     // transaction launched, waiting for eng_done
    logic [7:0] rd_data_reg;  // registered buffer read of idx_reg
    logic [7:0] page_mem [16];

    logic [5:0] len_sum;
    logic       len_ok;
    logic [7:0] devsel_byte;

    assign len_sum     = {2'b00, mem_addr[3:0]} + {1'b0, len};
    assign len_ok      = (len != 5'd0) && (len_sum <= 6'd16);
    assign devsel_byte = {4'b1010, chip_reg, 1'b0};

`ifdef PAGESEQ_ACKPOLL_EN
    localparam logic [7:0] POLL_LIMIT_W = POLL_LIMIT[7:0];
    logic [7:0] poll_cnt_reg;
`else
    logic poll_limit_unused;
    assign poll_limit_unused = (POLL_LIMIT > 0);
`endif

    // Page buffer: no reset so it maps onto block RAM. The read is free
    // running on idx_reg; idx_reg advances at each data launch, so the next
    // byte is ready long before the next launch.
    always_ff @(posedge clock) begin
        if (buf_we && !busy) begin
            page_mem[buf_waddr] <= buf_wdata;
        end
        rd_data_reg <= page_mem[idx_reg];
    end

    // Each transacting state spends its first cycle launching (eng_go and
    // the eng_* fields are registered together), then waits for eng_done.
    // Fields only change at launch, so they hold steady until completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= 8'd0;
            chip_reg    <= 3'd0;
            idx_reg     <= 4'd0;
            remain_reg  <= 5'd0;
            wait_reg    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            eng_go      <= 1'b0;
            eng_start   <= 1'b0;
            eng_byte_en <= 1'b0;
            eng_stop    <= 1'b0;
            eng_byte    <= 8'd0;
            err_code    <= 2'd0;
`ifdef PAGESEQ_ACKPOLL_EN
            poll_cnt_reg <= 8'd0;
`endif
        end else begin
            eng_go <= 1'b0;
            done   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (!len_ok) begin
                            err_code  <= 2'd1;
                            state_reg <= ST_FINISH;
                        end else begin
                            addr_reg   <= mem_addr;
                            chip_reg   <= chip_sel;
                            idx_reg    <= mem_addr[3:0];
                            remain_reg <= len;
                            err_code   <= 2'd0;
                            busy       <= 1'b1;
                            wait_reg   <= 1'b0;
`ifdef PAGESEQ_ACKPOLL_EN
                            poll_cnt_reg <= 8'd0;
`endif
                            state_reg  <= ST_DEVSEL;
                        end
                    end
                end
                ST_DEVSEL: begin
                    if (!wait_reg) begin
                        eng_go      <= 1'b1;
                        eng_start   <= 1'b1;
                        eng_byte_en <= 1'b1;
                        eng_stop    <= 1'b0;
                        eng_byte    <= devsel_byte;
                        wait_reg    <= 1'b1;
                    end else if (eng_done) begin
                        wait_reg <= 1'b0;
                        if (!eng_ack) begin
                            err_code  <= 2'd2;
                            state_reg <= ST_ABORT;
                        end else begin
                            state_reg <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (!wait_reg) begin
                        eng_go      <= 1'b1;
                        eng_start   <= 1'b0;
                        eng_byte_en <= 1'b1;
                        eng_stop    <= 1'b0;
                        eng_byte    <= addr_reg;
                        wait_reg    <= 1'b1;
                    end else if (eng_done) begin
                        wait_reg <= 1'b0;
                        if (!eng_ack) begin
                            err_code  <= 2'd2;
                            state_reg <= ST_ABORT;
                        end else begin
                            state_reg <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (!wait_reg) begin
                        eng_go      <= 1'b1;
                        eng_start   <= 1'b0;
                        eng_byte_en <= 1'b1;
                        eng_stop    <= (remain_reg == 5'd1);
                        eng_byte    <= rd_data_reg;
                        idx_reg     <= idx_reg + 4'd1;
                        wait_reg    <= 1'b1;
                    end else if (eng_done) begin
                        wait_reg <= 1'b0;
                        if (!eng_ack) begin
                            err_code  <= 2'd2;
                            state_reg <= ST_ABORT;
                        end else if (remain_reg == 5'd1) begin
`ifdef PAGESEQ_ACKPOLL_EN
                            state_reg <= ST_POLL;
`else
                            state_reg <= ST_FINISH;
`endif
                        end else begin
                            remain_reg <= remain_reg - 5'd1;
                        end
                    end
                end
                ST_ABORT: begin
                    if (!wait_reg) begin
                        eng_go      <= 1'b1;
                        eng_start   <= 1'b0;
                        eng_byte_en <= 1'b0;
                        eng_stop    <= 1'b1;
                        eng_byte    <= 8'd0;
                        wait_reg    <= 1'b1;
                    end else if (eng_done) begin
                        wait_reg  <= 1'b0;
                        state_reg <= ST_FINISH;
                    end
                end
`ifdef PAGESEQ_ACKPOLL_EN
                ST_POLL: begin
                    if (!wait_reg) begin
                        eng_go       <= 1'b1;
                        eng_start    <= 1'b1;
                        eng_byte_en  <= 1'b1;
                        eng_stop     <= 1'b1;
                        eng_byte     <= devsel_byte;
                        poll_cnt_reg <= poll_cnt_reg + 8'd1;
                        wait_reg     <= 1'b1;
                    end else if (eng_done) begin
                        wait_reg <= 1'b0;
                        if (eng_ack) begin
                            state_reg <= ST_FINISH;
                        end else if (poll_cnt_reg >= POLL_LIMIT_W) begin
                            err_code  <= 2'd3;
                            state_reg <= ST_FINISH;
                        end
                    end
                end
`endif
                ST_FINISH: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_page_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_page_sequencer
//
// Scoreboard bench: each page request pushes the transactions it should
// produce into exp_q; a behavioural byte engine pops and compares one entry
// per eng_go and answers with eng_done/eng_ack after a short delay.
// Build with +define+PAGESEQ_ACKPOLL_EN to exercise ACK polling.
// ---------------------------------------------------------------------------
module tb_i2c_page_sequencer;

`ifdef PAGESEQ_ACKPOLL_EN
    localparam int TB_POLL_LIMIT = 6;
    localparam int NP = 1;   // one ACKed poll after every good page
`else
    localparam int TB_POLL_LIMIT = 200;
    localparam int NP = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] chip_sel = 3'd0;
    logic [7:0] mem_addr = 8'd0;
    logic [4:0] len = 5'd0;
    logic       buf_we = 1'b0;
    logic [3:0] buf_waddr = 4'd0;
    logic [7:0] buf_wdata = 8'd0;
    logic       eng_go, eng_start, eng_byte_en, eng_stop;
    logic [7:0] eng_byte;
    logic       eng_done, eng_ack;
    logic       busy, done;
    logic [1:0] err_code;

    always #5 clock = ~clock;

    i2c_page_sequencer #(.POLL_LIMIT(TB_POLL_LIMIT)) dut (
        .clock(clock), .reset(reset), .start(start), .chip_sel(chip_sel),
        .mem_addr(mem_addr), .len(len), .buf_we(buf_we), .buf_waddr(buf_waddr),
        .buf_wdata(buf_wdata), .eng_go(eng_go), .eng_start(eng_start),
        .eng_byte_en(eng_byte_en), .eng_stop(eng_stop), .eng_byte(eng_byte),
        .eng_done(eng_done), .eng_ack(eng_ack), .busy(busy), .done(done),
        .err_code(err_code)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       s;
        logic       b;
        logic       p;
        logic [7:0] v;
        logic       care;   // byte value checked
    } tx_t;

    tx_t        exp_q[$];
    logic [7:0] tb_buf [16];

    int go_total = 0, poll_total = 0;
    int go_base = 0, poll_base = 0;
    int nack_idx = -1;   // transaction index (within one run) to NACK
    int poll_nacks = 0;  // polls to NACK before ACKing

    function automatic tx_t mk(input logic s, input logic b, input logic p,
                               input logic [7:0] v, input logic care);
        tx_t t;
        t.s = s; t.b = b; t.p = p; t.v = v; t.care = care;
        return t;
    endfunction

    // Behavioural byte engine
    tx_t        eng_e;
    logic       eng_ack_v;
    logic [10:0] eng_fields;
    initial begin
        eng_done = 1'b0;
        eng_ack  = 1'b0;
        forever begin
            @(negedge clock);
            if (eng_go === 1'b1) begin
                eng_fields = {eng_start, eng_byte_en, eng_stop, eng_byte};
                check("tx_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    eng_e = exp_q.pop_front();
                    check("tx_flags", {eng_start, eng_byte_en, eng_stop},
                          {eng_e.s, eng_e.b, eng_e.p});
                    if (eng_e.care) check("tx_byte", eng_byte, eng_e.v);
                end
                eng_ack_v = ((go_total - go_base) != nack_idx);
                if (eng_start && eng_byte_en && eng_stop) begin
                    if ((poll_total - poll_base) < poll_nacks) eng_ack_v = 1'b0;
                    poll_total++;
                end
                go_total++;
                @(negedge clock);
                check("go_single", eng_go, 0);
                @(negedge clock);
                if (busy) check("tx_stable", {eng_start, eng_byte_en, eng_stop, eng_byte}, eng_fields);
                eng_ack  = eng_ack_v;
                eng_done = 1'b1;
                @(negedge clock);
                eng_done = 1'b0;
                eng_ack  = 1'b0;
            end
        end
    end

    task automatic write_buf(input logic [3:0] a, input logic [7:0] d, input bit taken);
        @(negedge clock);
        buf_we = 1'b1; buf_waddr = a; buf_wdata = d;
        @(negedge clock);
        buf_we = 1'b0;
        if (taken) tb_buf[a] = d;
    endtask

    task automatic do_start(input logic [2:0] cs, input logic [7:0] ma, input logic [4:0] ln);
        @(negedge clock);
        start = 1'b1; chip_sel = cs; mem_addr = ma; len = ln;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic expect_page(input logic [2:0] cs, input logic [7:0] ma, input int ln,
                               input int npoll, output int n);
        logic [3:0] ix;
        exp_q.push_back(mk(1, 1, 0, {4'b1010, cs, 1'b0}, 1));
        exp_q.push_back(mk(0, 1, 0, ma, 1));
        for (int i = 0; i < ln; i++) begin
            ix = ma[3:0] + 4'(i);
            exp_q.push_back(mk(0, 1, (i == ln - 1), tb_buf[ix], 1));
        end
        for (int i = 0; i < npoll; i++) exp_q.push_back(mk(1, 1, 1, {4'b1010, cs, 1'b0}, 1));
        n = ln + 2 + npoll;
    endtask

    task automatic run_page(input string tag, input logic [2:0] cs, input logic [7:0] ma,
                            input logic [4:0] ln, input logic [1:0] exp_err, input int exp_gos,
                            input logic exp_busy, input bit disturb);
        logic       seen;
        logic [1:0] err;
        go_base   = go_total;
        poll_base = poll_total;
        do_start(cs, ma, ln);
        check({tag, "_busy"}, busy, exp_busy);
        if (disturb) begin
            write_buf(4'd12, 8'hEE, 0);
            do_start(3'd7, 8'h00, 5'd1);
        end
        seen = 1'b0;
        err  = 2'd0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                err  = err_code;
            end else begin
                @(negedge clock);
            end
        end
        check({tag, "_done"}, seen, 1);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_gos"}, go_total - go_base, exp_gos);
        check({tag, "_queue"}, exp_q.size(), 0);
        @(negedge clock);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        exp_q.delete();
    endtask

    int n;
    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_go", eng_go, 0);
        check("rst_fields", {eng_start, eng_byte_en, eng_stop, eng_byte}, 0);
        check("rst_err", err_code, 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) write_buf(4'(i), 8'(i), 1);

        // Full 16-byte page at 0x20
        expect_page(3'd0, 8'h20, 16, NP, n);
        run_page("page16", 3'd0, 8'h20, 5'd16, 2'd0, n, 1, 0);

        // Length errors
        run_page("badlen", 3'd0, 8'h0E, 5'd3, 2'd1, 0, 0, 0);
        run_page("len0", 3'd0, 8'h20, 5'd0, 2'd1, 0, 0, 0);
        run_page("len17", 3'd0, 8'h00, 5'd17, 2'd1, 0, 0, 0);

        // chip_sel into devsel, tail of the page
        expect_page(3'd5, 8'h1C, 4, NP, n);
        run_page("cs5", 3'd5, 8'h1C, 5'd4, 2'd0, n, 1, 0);

        // Exact page-end boundary (13 + 3 = 16)
        for (int i = 0; i < 16; i++) write_buf(4'(i), 8'(i * 17) ^ 8'h3C, 1);
        expect_page(3'd3, 8'h5D, 3, NP, n);
        run_page("edge16", 3'd3, 8'h5D, 5'd3, 2'd0, n, 1, 0);

        // start and buf_we while busy are ignored
        expect_page(3'd2, 8'h0C, 1, NP, n);
        run_page("busy_ign", 3'd2, 8'h0C, 5'd1, 2'd0, n, 1, 1);
        expect_page(3'd1, 8'h0C, 1, NP, n);
        run_page("buf_kept", 3'd1, 8'h0C, 5'd1, 2'd0, n, 1, 0);

        // NACK handling
        nack_idx = 1;
        exp_q.push_back(mk(1, 1, 0, 8'hA0, 1));
        exp_q.push_back(mk(0, 1, 0, 8'h33, 1));
        exp_q.push_back(mk(0, 0, 1, 8'h00, 0));
        run_page("nack_addr", 3'd0, 8'h33, 5'd2, 2'd2, 3, 1, 0);

        nack_idx = 0;
        exp_q.push_back(mk(1, 1, 0, 8'hA4, 1));
        exp_q.push_back(mk(0, 0, 1, 8'h00, 0));
        run_page("nack_dev", 3'd2, 8'h33, 5'd2, 2'd2, 2, 1, 0);

        nack_idx = 3;
        exp_q.push_back(mk(1, 1, 0, 8'hA0, 1));
        exp_q.push_back(mk(0, 1, 0, 8'h40, 1));
        exp_q.push_back(mk(0, 1, 0, tb_buf[0], 1));
        exp_q.push_back(mk(0, 1, 0, tb_buf[1], 1));
        exp_q.push_back(mk(0, 0, 1, 8'h00, 0));
        run_page("nack_data", 3'd0, 8'h40, 5'd4, 2'd2, 5, 1, 0);
        nack_idx = -1;

`ifdef PAGESEQ_ACKPOLL_EN
        poll_nacks = 5;
        expect_page(3'd0, 8'h60, 2, 6, n);
        run_page("poll_ok", 3'd0, 8'h60, 5'd2, 2'd0, n, 1, 0);
        poll_nacks = 1000;
        expect_page(3'd0, 8'h60, 2, TB_POLL_LIMIT, n);
        run_page("poll_tmo", 3'd0, 8'h60, 5'd2, 2'd3, n, 1, 0);
        poll_nacks = 0;
`endif

        // Reset while data byte 2 is outstanding
        go_base = go_total;
        exp_q.push_back(mk(1, 1, 0, 8'hA0, 1));
        exp_q.push_back(mk(0, 1, 0, 8'h48, 1));
        exp_q.push_back(mk(0, 1, 0, tb_buf[8], 1));
        exp_q.push_back(mk(0, 1, 0, tb_buf[9], 1));
        do_start(3'd0, 8'h48, 5'd8);
        for (int k = 0; k < 500 && (go_total - go_base) < 4; k++) @(negedge clock);
        check("rst_mid_reach", go_total - go_base, 4);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_go", eng_go, 0);
        check("rst_mid_fields", {eng_start, eng_byte_en, eng_stop, eng_byte}, 0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("rst_mid_nogo", go_total - go_base, 4);
        check("rst_mid_idle", {busy, done}, 0);
        exp_q.delete();
        expect_page(3'd0, 8'h48, 8, NP, n);
        run_page("after_rst", 3'd0, 8'h48, 5'd8, 2'd0, n, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_page_sequencer.md
I2C_PAGE_SEQUENCER -- requirements
Module: i2c_page_sequencer

Interface
REQ-001 Parameter POLL_LIMIT, default 200, SHALL set the maximum number of ACK-poll attempts (1..255).
REQ-002 clock  in  1  SHALL be the single system clock; all state SHALL update on posedge clock.
REQ-003 reset  in  1  SHALL be synchronous and active-high.
REQ-004 start  in  1  SHALL be a one-cycle pulse requesting a page write.
REQ-005 chip_sel  in  3  SHALL carry the E2..E0 pin values placed in devsel bits 3..1.
REQ-006 mem_addr  in  8  SHALL be the start byte address within the chip, sampled on start.
REQ-007 len  in  5  SHALL be the byte count (1..16), sampled on start.
REQ-008 buf_we, buf_waddr[3:0], buf_wdata[7:0]  in  SHALL write the 16x8 page buffer.
REQ-009 eng_go  out  1  SHALL be a one-cycle pulse launching one byte-engine transaction.
REQ-010 eng_start, eng_byte_en, eng_stop  out  1 each  SHALL select the start, byte and stop phases.
REQ-011 eng_byte  out  8  SHALL be the byte to transmit.
REQ-012 eng_done  in  1  SHALL be the engine's one-cycle completion pulse; eng_ack  in  1  SHALL be valid with it (1 = ACK).
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); err_code  out  2 (0 ok, 1 bad length, 2 NACK, 3 poll timeout).

Function
REQ-014 States SHALL be IDLE, DEVSEL, ADDR, DATA, ABORT, POLL, FINISH.
REQ-015 start in IDLE with len==0 or mem_addr[3:0]+len>16 SHALL go to FINISH with err_code=1 and no eng_go.
REQ-016 Valid start SHALL latch inputs, clear err_code, set busy next cycle, and enter DEVSEL.
REQ-017 DEVSEL SHALL issue eng_start=1, eng_byte_en=1, eng_stop=0, eng_byte={4'b1010,chip_sel,1'b0}.
REQ-018 ADDR SHALL issue eng_start=0, eng_byte_en=1, eng_stop=0, eng_byte=latched mem_addr.
REQ-019 DATA SHALL send buffer[(mem_addr[3:0]+i) mod 16] for i=0..len-1, eng_stop=1 only on the last byte.
REQ-020 eng_go SHALL pulse exactly one cycle after state entry; eng_* fields SHALL stay stable until eng_done.
REQ-021 eng_done with eng_ack=0 in DEVSEL/ADDR/DATA SHALL set err_code=2 and enter ABORT.
REQ-022 ABORT SHALL issue one stop-only transaction (eng_start=0, eng_byte_en=0, eng_stop=1), then enter FINISH.
REQ-023 Last DATA eng_done with ACK SHALL enter POLL (PAGESEQ_ACKPOLL_EN defined) or FINISH (undefined).
REQ-024 FINISH SHALL pulse done for one cycle, drop busy, and return to IDLE the next cycle.
REQ-025 start while busy SHALL be ignored; buf_we while busy SHALL be ignored.
REQ-026 eng_done outside a pending transaction SHALL be ignored.
REQ-027 Data index arithmetic SHALL be 4-bit and wrap from 15 to 0.

Reset
REQ-028 reset SHALL force IDLE, busy=0, done=0, eng_go=0, eng_start=0, eng_byte_en=0, eng_stop=0, eng_byte=0, err_code=0, poll counter=0.
REQ-029 reset mid-transaction SHALL abandon it with no further eng_go; buffer contents SHALL be undefined after reset.

Configuration
REQ-030 With PAGESEQ_ACKPOLL_EN defined, POLL SHALL repeat transactions with eng_start=1, eng_byte_en=1, eng_stop=1 and the devsel-write byte until ACK, then enter FINISH.
REQ-031 With PAGESEQ_ACKPOLL_EN defined, POLL_LIMIT NACKed attempts SHALL set err_code=3 and enter FINISH.
REQ-032 Without PAGESEQ_ACKPOLL_EN, the POLL state and poll counter SHALL be absent.

Verification
REQ-033 Fill buffer 0x00..0x0F, start mem_addr=0x20 len=16, engine always ACKs -> 18 eng_go: devsel 0xA0, addr 0x20, data 0x00..0x0F, eng_stop only on 0x0F; done, err_code=0.
REQ-034 start mem_addr=0x0E len=3 -> err_code=1, done pulse, zero eng_go.
REQ-035 mem_addr=0x1C len=4, chip_sel=3'b101 -> devsel 0xAA; data from buffer indices 12,13,14,15.
REQ-036 NACK on the ADDR byte -> stop-only transaction follows, err_code=2, done pulse.
REQ-037 PAGESEQ_ACKPOLL_EN, poll NACKs 5 times then ACKs -> 6 poll transactions, err_code=0; always NACK with POLL_LIMIT=4 -> 4 polls, err_code=3.
REQ-038 reset asserted during DATA byte 2 -> next cycle busy=0, eng_go=0; new start then runs the full sequence from DEVSEL.
